// File: rtl/axi_burst_sched_pkg.sv
// Shared definitions for the AXI burst scheduler: default burst-length width,
// 4 KB boundary width, FSM state encoding and a small elaboration helper.
package axi_burst_sched_pkg;

  localparam int AXI_LEN_W_DEF = 8;
  localparam int BOUND_4K_W    = 12;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_LAUNCH,
    ST_WAIT,
    ST_FIN
  } state_e;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/axi_burst_sched_if.sv
// Scheduler-to-burst-engine link: run/addr/len/dir out, ready/error back.
interface axi_burst_sched_if
  import axi_burst_sched_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int AXI_LEN_W = AXI_LEN_W_DEF
);

  logic                 eng_run;
  logic                 eng_dir;
  logic [ADDR_W-1:0]    eng_addr;
  logic [AXI_LEN_W-1:0] eng_len;
  logic                 eng_ready;
  logic                 eng_error;

  modport master (
    output eng_run, eng_dir, eng_addr, eng_len,
    input  eng_ready, eng_error
  );

  modport slave (
    input  eng_run, eng_dir, eng_addr, eng_len,
    output eng_ready, eng_error
  );

endinterface

// File: rtl/axi_burst_len_calc.sv
// Combinational burst sizing: min(remaining, 2^AXI_LEN_W, beats left in the
// current 4 KB page). Only the in-page address bits are needed.
module axi_burst_len_calc
  import axi_burst_sched_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int AXI_LEN_W = AXI_LEN_W_DEF,
  parameter int CNT_W     = 16
) (
  input  logic [BOUND_4K_W-1:0] addr_lo,
  input  logic [CNT_W-1:0]      remaining,
  output logic [AXI_LEN_W:0]    burst,
  output logic [AXI_LEN_W-1:0]  eng_len
);

  localparam int OFF_W = $clog2(DATA_W / 8);
  localparam int B4K_W = BOUND_4K_W + 1;
  localparam int CW    = max_int(max_int(CNT_W, B4K_W), AXI_LEN_W + 1);

  logic [B4K_W-1:0] span_bytes;
  logic [B4K_W-1:0] beats4k;
  logic [CW-1:0]    rem_w;
  logic [CW-1:0]    max_w;
  logic [CW-1:0]    b4k_w;
  logic [CW-1:0]    burst_w;

  always_comb begin
    // A page-aligned address yields the full 4096-byte span.
    span_bytes = B4K_W'(1 << BOUND_4K_W) - {1'b0, addr_lo};
    beats4k    = span_bytes >> OFF_W;
    rem_w      = CW'(remaining);
    max_w      = CW'(1) << AXI_LEN_W;
    b4k_w      = CW'(beats4k);
    burst_w    = rem_w;
    if (max_w < burst_w) burst_w = max_w;
    if (b4k_w < burst_w) burst_w = b4k_w;
    burst   = (AXI_LEN_W + 1)'(burst_w);
    eng_len = AXI_LEN_W'(burst_w - CW'(1));
  end

endmodule

// File: rtl/axi_burst_sched.sv
// Splits one multi-word transfer into legal AXI4 INCR bursts and sequences the
// engine. Optional macro AXI_BURST_SCHED_ABORT_ON_ERR_EN stops at first error.
module axi_burst_sched
  import axi_burst_sched_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int AXI_LEN_W = AXI_LEN_W_DEF,
  parameter int CNT_W     = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               dir,
  input  logic [ADDR_W-1:0]  addr,
  input  logic [CNT_W-1:0]   nwords,
  output logic               busy,
  output logic               done,
  output logic               error,
  axi_burst_sched_if.master  eng
);

  localparam int                OFF_W      = $clog2(DATA_W / 8);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(DATA_W / 8 - 1);

  state_e               state_q, state_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic [CNT_W-1:0]     rem_q, rem_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 error_q, error_d;
  logic                 eng_run_q, eng_run_d;
  logic                 eng_dir_q, eng_dir_d;
  logic [ADDR_W-1:0]    eng_addr_q, eng_addr_d;
  logic [AXI_LEN_W-1:0] eng_len_q, eng_len_d;

  logic [AXI_LEN_W:0]   burst;
  logic [AXI_LEN_W-1:0] calc_len;

  axi_burst_len_calc #(
    .DATA_W    (DATA_W),
    .AXI_LEN_W (AXI_LEN_W),
    .CNT_W     (CNT_W)
  ) u_len_calc (
    .addr_lo   (addr_q[BOUND_4K_W-1:0]),
    .remaining (rem_q),
    .burst     (burst),
    .eng_len   (calc_len)
  );

  always_comb begin
    // NOTE: every _d gets its hold value first so no path can infer a latch.
    state_d    = state_q;
    addr_d     = addr_q;
    rem_d      = rem_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    error_d    = error_q;
    eng_run_d  = 1'b0;
    eng_dir_d  = eng_dir_q;
    eng_addr_d = eng_addr_q;
    eng_len_d  = eng_len_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          addr_d    = addr & ALIGN_MASK;
          rem_d     = nwords;
          eng_dir_d = dir;
          error_d   = 1'b0;
          busy_d    = 1'b1;
          state_d   = (nwords == '0) ? ST_FIN : ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (eng.eng_ready) begin
          eng_run_d  = 1'b1;
          eng_addr_d = addr_q;
          eng_len_d  = calc_len;
          // Address wraps modulo 2^ADDR_W; burst never exceeds rem_q.
          addr_d     = addr_q + (ADDR_W'(burst) << OFF_W);
          rem_d      = rem_q - CNT_W'(burst);
          state_d    = ST_LAUNCH;
        end
      end
      ST_LAUNCH: state_d = ST_WAIT;
      ST_WAIT: begin
        if (eng.eng_ready) begin
          error_d = error_q | eng.eng_error;
`ifdef AXI_BURST_SCHED_ABORT_ON_ERR_EN
          state_d = ((rem_q == '0) || eng.eng_error) ? ST_FIN : ST_ISSUE;
`else
          state_d = (rem_q == '0) ? ST_FIN : ST_ISSUE;
`endif
        end
      end
      ST_FIN: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      rem_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      eng_run_q  <= 1'b0;
      eng_dir_q  <= 1'b0;
      eng_addr_q <= '0;
      eng_len_q  <= '0;
    end else begin
      // NOTE: non-blocking only; blocking here would race every reader of these flops.
      state_q    <= state_d;
      addr_q     <= addr_d;
      rem_q      <= rem_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      error_q    <= error_d;
      eng_run_q  <= eng_run_d;
      eng_dir_q  <= eng_dir_d;
      eng_addr_q <= eng_addr_d;
      eng_len_q  <= eng_len_d;
    end
  end

  assign busy         = busy_q;
  assign done         = done_q;
  assign error        = error_q;
  assign eng.eng_run  = eng_run_q;
  assign eng.eng_dir  = eng_dir_q;
  assign eng.eng_addr = eng_addr_q;
  assign eng.eng_len  = eng_len_q;

endmodule
